// File: rtl/ps2_lane_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_lane_if
// Purpose  : PS/2 pin inputs and lane/code outputs of the lane decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_lane_if #(
  parameter int LANES = 3
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  logic             PS2_CLK;
  logic             PS2_DATA;
  logic [LANES-1:0] lane;
  logic [IW-1:0]    lane_idx;
  logic [7:0]       code;
  logic             code_valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output PS2_CLK, PS2_DATA,
    input  lane, lane_idx, code, code_valid, frame_err, busy
  );

  modport slave (
    input  PS2_CLK, PS2_DATA,
    output lane, lane_idx, code, code_valid, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/ps2_lane_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_lane_decoder
// Purpose  : PS/2 frame receiver with E0/F0 prefix stripping and a one-hot
//            lane tracker stepped by left/right make codes with cooldown.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_lane_decoder #(
  parameter int         CLK_DIV       = 250,
  parameter int         TIMEOUT_TICKS = 4000,
  parameter int         LANES         = 3,
  parameter int         START_LANE    = 1,
  parameter int         COOLDOWN      = 25000000,
  parameter logic [7:0] KEY_LEFT      = 8'h6B,
  parameter logic [7:0] KEY_RIGHT     = 8'h74
) (
  input  wire logic   CLK,
  input  wire logic   RST,
  ps2_lane_if.slave   bus
);
  localparam int IW = $clog2(LANES);
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [7:0] C_PFX_EXT = 8'hE0;
  localparam logic [7:0] C_PFX_BRK = 8'hF0;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_prev;
  logic [DW-1:0] r_div;
  logic [9:0]    r_shift;
  logic [3:0]    r_bitcnt;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_code;
  logic          r_code_valid, r_frame_err;
  logic          r_brk;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cool;

  logic          w_tick, w_fall, w_frame_ok, w_busy;
  logic [10:0]   w_frame;

  assign w_tick     = (r_div == DW'(CLK_DIV - 1));
  assign w_fall     = w_tick & r_clk_prev & ~r_clk_s2;
  assign w_frame    = {r_dat_s2, r_shift};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
  assign w_busy     = (r_cool != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_div    <= '0;
    end else begin
      r_clk_s1 <= bus.PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.PS2_DATA;
      r_dat_s2 <= r_dat_s1;
      r_div    <= w_tick ? '0 : r_div + DW'(1);
    end
  end

  // The 11th bit is checked straight off the synchroniser so the result
  // pulses in the cycle right after the sampling tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clk_prev   <= 1'b1;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_tmo        <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_tick) begin
        r_clk_prev <= r_clk_s2;
        if (w_fall) begin
          r_tmo <= '0;
          if (r_bitcnt == 4'd10) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            if (w_frame_ok) begin
              r_code       <= w_frame[8:1];
              r_code_valid <= 1'b1;
            end else begin
              r_frame_err  <= 1'b1;
            end
          end else begin
            r_shift  <= {r_dat_s2, r_shift[9:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end else if (r_bitcnt != 4'd0) begin
          if (r_tmo == TW'(TIMEOUT_TICKS - 1)) begin
            r_bitcnt <= '0;
            r_tmo    <= '0;
            r_shift  <= '0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
      end
    end
  end

  // E0 only marks a non-final byte; it never gates a move, so no flag is kept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx  <= IW'(START_LANE);
      r_cool <= '0;
      r_brk  <= 1'b0;
    end else begin
      if (w_busy) r_cool <= r_cool - CW'(1);
      if (r_frame_err) begin
        r_brk <= 1'b0;
      end else if (r_code_valid) begin
        if (r_code == C_PFX_BRK) begin
          r_brk <= 1'b1;
        end else if (r_code != C_PFX_EXT) begin
          r_brk <= 1'b0;
          if (!r_brk && !w_busy) begin
            if (r_code == KEY_LEFT && r_idx != '0) begin
              r_idx  <= r_idx - IW'(1);
              r_cool <= CW'(COOLDOWN);
            end else if (r_code == KEY_RIGHT && r_idx != IW'(LANES - 1)) begin
              r_idx  <= r_idx + IW'(1);
              r_cool <= CW'(COOLDOWN);
            end
          end
        end
      end
    end
  end

  assign bus.lane       = LANES'(1) << r_idx;
  assign bus.lane_idx   = r_idx;
  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_ps2_lane_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_lane_decoder
// Purpose  : Directed and random PS/2 frames against a behavioural lane model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_lane_decoder;
  localparam int         CLK_DIV       = 4;
  localparam int         TIMEOUT_TICKS = 20;
  localparam int         LANES         = 3;
  localparam int         START_LANE    = 1;
  localparam int         COOLDOWN      = 300;
  localparam logic [7:0] KL            = 8'h6B;
  localparam logic [7:0] KR            = 8'h74;
  localparam int         HALF          = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_lane_if #(.LANES(LANES)) bus ();

  ps2_lane_decoder #(
    .CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS), .LANES(LANES),
    .START_LANE(START_LANE), .COOLDOWN(COOLDOWN), .KEY_LEFT(KL), .KEY_RIGHT(KR)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];   // {is_error, byte} per complete frame sent

  int         m_idx  = START_LANE;
  int         m_cool = 0;
  bit         m_brk  = 1'b0;
  logic [7:0] m_code = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [8:0] e;
    bit good, moved;
    good  = 1'b0;
    moved = 1'b0;
    e     = '0;
    if (rst) begin
      m_idx = START_LANE; m_cool = 0; m_brk = 1'b0; m_code = 8'h00;
    end else begin
      if (bus.code_valid && bus.frame_err) begin
        check("both_pulses", 32'd1, 32'd0);
      end else if (bus.code_valid || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          check("spurious_pulse", {bus.code_valid, bus.frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_err", {31'd0, bus.frame_err}, {31'd0, e[8]});
          if (!e[8]) begin
            good   = 1'b1;
            m_code = e[7:0];
          end else begin
            m_brk = 1'b0;
          end
        end
      end
      check("lane",     {29'd0, bus.lane}, 32'd1 << m_idx);
      check("lane_idx", {30'd0, bus.lane_idx}, m_idx);
      check("busy",     {31'd0, bus.busy}, (m_cool != 0) ? 32'd1 : 32'd0);
      check("code",     {24'd0, bus.code}, {24'd0, m_code});
      if (good) begin
        if (m_code == 8'hF0) begin
          m_brk = 1'b1;
        end else if (m_code != 8'hE0) begin
          if (!m_brk && m_cool == 0) begin
            if (m_code == KL && m_idx > 0) begin
              m_idx--; moved = 1'b1;
            end else if (m_code == KR && m_idx < LANES - 1) begin
              m_idx++; moved = 1'b1;
            end
          end
          m_brk = 1'b0;
        end
      end
      if (moved) m_cool = COOLDOWN;
      else if (m_cool > 0) m_cool--;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // kind: 0 good, 1 parity flipped, 2 start high, 3 stop low
  task automatic send_frame(input logic [7:0] b, input int kind, input int nbits);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (kind == 1) f[9]  = ~f[9];
    if (kind == 2) f[0]  = 1'b1;
    if (kind == 3) f[10] = 1'b0;
    if (nbits == 11) exp_q.push_back({kind != 0, b});
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); bus.PS2_DATA = f[i];
      idle(HALF); bus.PS2_CLK = 1'b0;
      idle(HALF); bus.PS2_CLK = 1'b1;
    end
    @(negedge clk); bus.PS2_DATA = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin : main
    int r, kind;
    logic [7:0] b;
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    check("rst_lane", {29'd0, bus.lane}, 32'b010);
    check("rst_idx",  {30'd0, bus.lane_idx}, 32'd1);
    check("rst_pulses", {bus.code_valid, bus.frame_err}, 32'd0);
    check("rst_busy_code", {bus.busy, bus.code}, 32'd0);

    send_frame(8'h74, 0, 11); idle(20);
    check("r_code", {24'd0, bus.code}, 32'h74);
    check("r_lane", {29'd0, bus.lane}, 32'b100);
    check("r_busy", {31'd0, bus.busy}, 32'd1);
    idle(COOLDOWN);
    check("r_busy_done", {31'd0, bus.busy}, 32'd0);

    send_frame(8'hE0, 0, 11); send_frame(8'hF0, 0, 11); send_frame(8'h74, 0, 11);
    idle(20);
    check("rel_lane", {29'd0, bus.lane}, 32'b100);
    check("rel_busy", {31'd0, bus.busy}, 32'd0);
    check("rel_pulses_seen", exp_q.size(), 32'd0);

    send_frame(KL, 0, 11); send_frame(KL, 0, 11); idle(20);
    check("cool_idx", {30'd0, bus.lane_idx}, 32'd1);
    idle(COOLDOWN);
    send_frame(8'hE0, 0, 11); send_frame(KL, 0, 11); idle(COOLDOWN + 20);
    check("ext_left_idx", {30'd0, bus.lane_idx}, 32'd0);
    send_frame(KL, 0, 11); idle(20);
    check("edge_idx",  {30'd0, bus.lane_idx}, 32'd0);
    check("edge_busy", {31'd0, bus.busy}, 32'd0);

    send_frame(KR, 1, 11); idle(20);
    check("perr_code", {24'd0, bus.code}, {24'd0, KL});
    check("perr_lane", {29'd0, bus.lane}, 32'b001);
    send_frame(KR, 0, 11); idle(20);
    check("after_perr_lane", {29'd0, bus.lane}, 32'b010);
    idle(COOLDOWN);

    send_frame(8'h55, 0, 6); idle((TIMEOUT_TICKS + 4) * CLK_DIV);
    send_frame(KL, 0, 11); idle(20);
    check("tmo_code", {24'd0, bus.code}, {24'd0, KL});
    check("tmo_idx",  {30'd0, bus.lane_idx}, 32'd0);
    idle(COOLDOWN);

    send_frame(KR, 0, 5); do_reset(); idle(2);
    check("mid_rst_lane", {29'd0, bus.lane}, 32'b010);
    check("mid_rst_code_busy", {bus.busy, bus.code}, 32'd0);
    send_frame(KR, 0, 11); idle(20);
    check("post_rst_lane", {29'd0, bus.lane}, 32'b100);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        send_frame(8'($urandom), 0, $urandom_range(1, 10));
        idle((TIMEOUT_TICKS + 5) * CLK_DIV);
      end
      r = $urandom_range(0, 9);
      b = (r < 3) ? KL : (r < 6) ? KR : (r == 6) ? 8'hE0 : (r == 7) ? 8'hF0 : 8'($urandom);
      kind = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 3);
      send_frame(b, kind, 11);
      idle($urandom_range(0, 400));
    end

    idle(50);
    check("all_frames_reported", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
